// File: rtl/rs232_pkg.sv
// Shared types for the RS-232 transmit arbiter: FSM state encoding and
// the owner/grant index width derived from the requester count.
package rs232_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_STB,
    S_GUARD
  } arb_state_e;

  function automatic int unsigned owner_w(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid searching
// upward from last_grant+1, wrapping at NREQ-1 back to 0.
module rr_pick import rs232_pkg::*; #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]             valid,
  input  logic [owner_w(NREQ)-1:0]    last_grant,
  output logic [owner_w(NREQ)-1:0]    grant,
  output logic                        any
);

  localparam int unsigned OW = owner_w(NREQ);

  logic [OW-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = OW'((32'(last_grant) + k) % NREQ);
      if (!any && valid[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs232_tx_arb.sv
// Arbitrates NREQ byte streams onto a single UART sender, with packet
// locking, a lock-idle timeout and a post-strobe guard interval.
module rs232_tx_arb import rs232_pkg::*; #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned GUARD        = 10,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_en,
  input  logic                     tx_stb,
  output logic                     busy,
  output logic [owner_w(NREQ)-1:0] owner
);

  localparam int unsigned OW = owner_w(NREQ);
  localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam int unsigned TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  arb_state_e    state, state_nxt;
  logic          lock;
  logic [OW-1:0] last_grant;
  logic [GW-1:0] guard_cnt;
  logic [TW-1:0] to_cnt;
  logic [NREQ-1:0] lock_mask, elig;
  logic [OW-1:0] pick;
  logic          pick_any;

  // While locked, only the owner is fed to the picker, so the picker's
  // choice is the owner itself whenever the owner is valid.
  always_comb begin
    lock_mask        = '0;
    lock_mask[owner] = 1'b1;
    elig             = lock ? (req_valid & lock_mask) : req_valid;
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid      (elig),
    .last_grant (last_grant),
    .grant      (pick),
    .any        (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (pick_any)          state_nxt = S_WAIT_STB;
      S_WAIT_STB: if (tx_stb)            state_nxt = S_GUARD;
      S_GUARD:    if (guard_cnt == '0)   state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && pick_any) req_ready[pick] = 1'b1;
    busy = (state != S_IDLE) || lock;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data    <= '0;
      tx_en      <= 1'b0;
      owner      <= '0;
      last_grant <= OW'(NREQ - 1);
      lock       <= 1'b0;
      guard_cnt  <= '0;
      to_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            tx_data    <= req_data[{pick, 3'b000} +: 8];
            tx_en      <= 1'b1;
            owner      <= pick;
            last_grant <= pick;
            lock       <= ~req_last[pick];
            to_cnt     <= '0;
          end else if (lock && LOCK_TIMEOUT != 0 && !req_valid[owner]) begin
            if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
              lock   <= 1'b0;
              to_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
        end
        S_WAIT_STB: begin
          if (tx_stb) begin
            tx_en     <= 1'b0;
            guard_cnt <= GW'(GUARD - 1);
          end
        end
        S_GUARD: begin
          if (guard_cnt != '0) guard_cnt <= guard_cnt - GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rs232_tx_arb.md
RS232_TX_ARB -- requirements
Module: rs232_tx_arb

Interface
REQ-001 Parameter NREQ, default 4: number of byte-stream requesters; range 2..8.
REQ-002 Parameter GUARD, default 10: hold cycles after tx_stb; SHALL equal the sender PERIOD.
REQ-003 Parameter LOCK_TIMEOUT, default 1024: idle cycles before a packet lock is dropped; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all state on posedge clk.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  NREQ  per-requester byte valid.
REQ-007 req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 req_last  in  NREQ  marks the final byte of a packet.
REQ-009 req_ready  out  NREQ  one-hot accept; a byte transfers when valid&ready.
REQ-010 tx_data  out  8  byte presented to the UART sender data_byte input.
REQ-011 tx_en  out  1  holding register full; drives sender en.
REQ-012 tx_stb  in  1  sender strobe: byte committed, latched by sender GUARD cycles later.
REQ-013 busy  out  1  high when not IDLE or when lock is held.
REQ-014 owner  out  $clog2(NREQ)  current or most recent grantee.

Function
REQ-015 FSM states IDLE, WAIT_STB, GUARD; IDLE is the only state in which req_ready can be nonzero.
REQ-016 In IDLE with lock clear, the grantee SHALL be the first valid requester searching round-robin from last_grant+1, wrapping at NREQ-1 to 0.
REQ-017 In IDLE with lock set, only the lock owner is eligible; other requesters SHALL see req_ready=0.
REQ-018 req_ready[g] is combinational from state, lock and req_valid; it is asserted only for the eligible grantee whose req_valid is high.
REQ-019 On handshake: tx_data<=req_data[g], tx_en<=1, owner<=g, last_grant<=g, state->WAIT_STB; tx_en is high the cycle after the handshake.
REQ-020 Handshake with req_last=0 SHALL set lock (owner g); with req_last=1 SHALL clear lock.
REQ-021 In WAIT_STB, tx_en=1 and tx_data is stable; on tx_stb, tx_en<=0, guard counter<=GUARD-1, state->GUARD.
REQ-022 In GUARD, tx_data SHALL stay unchanged; counter decrements each cycle; at 0 state->IDLE.
REQ-023 tx_stb in IDLE or GUARD SHALL be ignored.
REQ-024 In IDLE with lock set and owner req_valid low, the timeout counter increments; reaching LOCK_TIMEOUT clears lock; counter resets on any handshake or when lock clears.
REQ-025 Round-robin fairness: with all requesters continuously valid and every byte last, grants SHALL cycle 0,1,...,NREQ-1,0.
REQ-026 req_valid dropping in WAIT_STB/GUARD has no effect; an accepted byte is always transmitted.

Reset
REQ-027 While rst_n=0: state=IDLE, tx_en=0, tx_data=0, req_ready=0, lock=0, owner=0, last_grant=NREQ-1 (requester 0 first), counters=0.
REQ-028 Reset assertion mid-byte SHALL drop the held byte and lock immediately; no byte is replayed after release.

Structure
REQ-029 Package rs232_pkg holds the FSM state enum and the owner-width constant derived from NREQ.
REQ-030 One sub-module rr_pick: combinational round-robin picker (inputs valid mask, last_grant; outputs grant index, any).

Verification
REQ-031 Bench pairs the block with the real UART sender at PERIOD=10, GUARD=10, NREQ=4, decodes the tx line.
REQ-032 Single byte: req_valid[2]=1, data 0x5A, last=1 -> req_ready[2] one cycle, tx_en next cycle, line shows 0x5A, lock stays 0.
REQ-033 Fairness: all four valid, bytes 0x10+i, last=1 -> line order 0x10,0x11,0x12,0x13,0x10.
REQ-034 Packet lock: req1 sends 0xA1,0xA2,0xA3 (last on 0xA3) while req0 and req3 valid -> three req1 bytes contiguous, then req3 (0x3x), then req0.
REQ-035 Lock timeout: LOCK_TIMEOUT=20, req1 sends 0xB1 last=0 then drops valid, req2 valid -> req2 granted exactly 20 idle cycles after entering IDLE.
REQ-036 Reset in WAIT_STB with lock set: rst_n low 3 cycles -> tx_en=0, lock=0, owner=0; first post-reset grant goes to req0 when all valid.
